useq_core: RTL

//  Parametrised two-phase microsequencer; next generation of the uControl/Timing pair.

---
 rtl/useq_core.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/useq_core.sv
// -----------------------------------------------------------------------------
// useq_core -- two-phase microsequencer
//
// Every active microcycle takes two clocks. In GEN the control-store address is
// stable and the external ROM returns the microword. In EXEC the datapath loads
// and the next microaddress is chosen from the P field. The sequencer also
// provides microsubroutine call/return through a small LIFO, flag-conditional
// branches, free-run and single-step control, and halts on a HALT microword or
// on a return-stack error.
//
// Parameters
//   UADDR_W      microaddress width (control-store depth 2**UADDR_W), >= 5
//   IR_W         instruction register width; IR[IR_W-1:IR_W-4] is the opcode
//   NFLAG        number of condition flags (1..4)
//   STACK_DEPTH  return-stack entries (>= 1)
//
// Optional feature (macro USEQ_BREAK_EN)
//   Adds bp_addr / bp_en inputs and a sticky bp_hit output. When enabled, a
//   microcycle is not started while the registered uaddr equals bp_addr; a step
//   edge or a low bp_en releases the breakpoint for one microcycle.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   clr        in   asynchronous active-high reset
//   run        in   1 = free-run, 0 = single-step
//   step       in   single-step request (level; rising edge used)
//   SWA, SWB   in   console mode switches, used by MODE dispatch
//   IR         in   instruction register
//   flags      in   condition flags, sampled in EXEC
//   ucode_P    in   P field of the current microword
//   ucode_UA   in   UA field of the current microword
//   uaddr      out  current microaddress
//   gen_en     out  high during GEN
//   exec_en    out  high during EXEC
//   halted     out  sequencer stopped (HALT microword or error)
//   err_ovf    out  sticky: CALL with a full stack
//   err_unf    out  sticky: RET with an empty stack
//   dbg_state_o out FSM state: 0 IDLE, 1 GEN, 2 EXEC, 3 HALT
//   dbg_sp_o   out  return-stack pointer (number of entries held)
//
// Handshake: there is no ready/valid pair. gen_en and exec_en are one-hot
// qualifiers decoded from the registered state; the datapath must load only
// in cycles where exec_en is high, and uaddr changes only on the clock that
// ends an EXEC cycle (or on clr).
// -----------------------------------------------------------------------------
module useq_core #(
    parameter int UADDR_W     = 8,
    parameter int IR_W        = 8,
    parameter int NFLAG       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic                                 run,
    input  logic                                 step,
    input  logic                                 SWA,
    input  logic                                 SWB,
    input  logic [IR_W-1:0]                      IR,
    input  logic [NFLAG-1:0]                     flags,
    input  logic [3:0]                           ucode_P,
    input  logic [UADDR_W-1:0]                   ucode_UA,
`ifdef USEQ_BREAK_EN
    input  logic [UADDR_W-1:0]                   bp_addr,
    input  logic                                 bp_en,
    output logic                                 bp_hit,
`endif
    output logic [UADDR_W-1:0]                   uaddr,
    output logic                                 gen_en,
    output logic                                 exec_en,
    output logic                                 halted,
    output logic                                 err_ovf,
    output logic                                 err_unf,
    output logic [1:0]                           dbg_state_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     dbg_sp_o
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // P-field encodings
    localparam logic [3:0] P_SEQ  = 4'd0;
    localparam logic [3:0] P_IRD  = 4'd1;
    localparam logic [3:0] P_MODE = 4'd2;
    localparam logic [3:0] P_BCND = 4'd3;
    localparam logic [3:0] P_CALL = 4'd4;
    localparam logic [3:0] P_RET  = 4'd5;
    localparam logic [3:0] P_HALT = 4'd6;

    state_t               state_q, state_d;
    logic [UADDR_W-1:0]   uaddr_q, uaddr_d;
    logic [SP_W-1:0]      sp_q, sp_d;
    logic [UADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic [UADDR_W-1:0]   stack_d [STACK_DEPTH];
    logic                 halted_q, halted_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_unf_q, err_unf_d;
    logic                 step_q;

`ifdef USEQ_BREAK_EN
    logic                 bp_hit_q, bp_hit_d;
    logic                 bp_rel_q, bp_rel_d;
`endif

    // Decoded helpers
    logic                 step_rise;
    logic [UADDR_W-1:0]   n1;
    logic [UADDR_W-1:0]   op_ext;
    logic [UADDR_W-1:0]   mode_ext;
    logic                 flag_sel;
    logic                 stack_full;
    logic                 stack_empty;
    logic [UADDR_W-1:0]   stack_top;
    logic                 unused_ir;

    // Only the opcode nibble and IR[1:0] steer the sequencer.
    assign unused_ir = ^IR;

    assign step_rise   = step & ~step_q;
    assign n1          = uaddr_q + UADDR_W'(1);   // wraps at 2**UADDR_W
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    always_comb begin
        op_ext        = '0;
        op_ext[3:0]   = IR[IR_W-1:IR_W-4];
        mode_ext      = '0;
        mode_ext[1:0] = {SWB, SWA};
    end

    // Flag select: an IR[1:0] that names a flag beyond NFLAG reads as 0.
    always_comb begin
        flag_sel = 1'b0;
        for (int i = 0; i < NFLAG; i++) begin
            if (IR[1:0] == 2'(i)) begin
                flag_sel = flags[i];
            end
        end
    end

    // Top of stack is entry sp-1; a mux avoids an out-of-range index when empty.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-address logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        uaddr_d   = uaddr_q;
        sp_d      = sp_q;
        stack_d   = stack_q;
        halted_d  = halted_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
`ifdef USEQ_BREAK_EN
        bp_hit_d  = bp_hit_q;
        bp_rel_d  = bp_rel_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
`ifdef USEQ_BREAK_EN
                // A step edge or a disabled breakpoint lets one microcycle through.
                if (!bp_en || step_rise) begin
                    bp_rel_d = 1'b1;
                end
                if (run || step_rise) begin
                    if (bp_en && (uaddr_q == bp_addr) && !bp_rel_q && !step_rise) begin
                        bp_hit_d = 1'b1;
                    end else begin
                        state_d = ST_GEN;
                    end
                end
`else
                if (run || step_rise) begin
                    state_d = ST_GEN;
                end
`endif
            end

            ST_GEN: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                unique case (ucode_P)
                    P_IRD:  uaddr_d = ucode_UA | op_ext;
                    P_MODE: uaddr_d = ucode_UA | mode_ext;
                    P_BCND: uaddr_d = flag_sel ? ucode_UA : n1;
                    P_CALL: begin
                        if (stack_full) begin
                            err_ovf_d = 1'b1;
                        end else begin
                            for (int i = 0; i < STACK_DEPTH; i++) begin
                                if (sp_q == SP_W'(i)) begin
                                    stack_d[i] = n1;
                                end
                            end
                            sp_d    = sp_q + SP_W'(1);
                            uaddr_d = ucode_UA;
                        end
                    end
                    P_RET: begin
                        if (stack_empty) begin
                            err_unf_d = 1'b1;
                        end else begin
                            sp_d    = sp_q - SP_W'(1);
                            uaddr_d = stack_top;
                        end
                    end
                    P_HALT: uaddr_d = uaddr_q;
                    default: uaddr_d = ucode_UA;   // SEQ and the unused codes 7..15
                endcase

                // Faults stop the sequencer on the clock that ends this EXEC.
                if ((ucode_P == P_HALT) ||
                    ((ucode_P == P_CALL) && stack_full) ||
                    ((ucode_P == P_RET) && stack_empty)) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (run) begin
`ifdef USEQ_BREAK_EN
                    if (bp_en && (uaddr_d == bp_addr)) begin
                        state_d  = ST_IDLE;
                        bp_hit_d = 1'b1;
                    end else begin
                        state_d = ST_GEN;
                    end
`else
                    state_d = ST_GEN;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
`ifdef USEQ_BREAK_EN
                bp_rel_d = 1'b0;
`endif
            end

            ST_HALT: begin
                state_d = ST_HALT;   // left only through clr
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            uaddr_q   <= '0;
            sp_q      <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            halted_q  <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            step_q    <= 1'b0;
`ifdef USEQ_BREAK_EN
            bp_hit_q  <= 1'b0;
            bp_rel_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            uaddr_q   <= uaddr_d;
            sp_q      <= sp_d;
            stack_q   <= stack_d;
            halted_q  <= halted_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            step_q    <= step;
`ifdef USEQ_BREAK_EN
            bp_hit_q  <= bp_hit_d;
            bp_rel_q  <= bp_rel_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign uaddr       = uaddr_q;
    assign gen_en      = (state_q == ST_GEN);
    assign exec_en     = (state_q == ST_EXEC);
    assign halted      = halted_q;
    assign err_ovf     = err_ovf_q;
    assign err_unf     = err_unf_q;
    assign dbg_state_o = state_q;
    assign dbg_sp_o    = sp_q;
`ifdef USEQ_BREAK_EN
    assign bp_hit      = bp_hit_q;
`endif

endmodule
